// File: rtl/note_sequencer.sv
// note_sequencer
// Buffers 40-bit note words in a small FIFO and plays them one at a time as a
// square wave on `tone`, toggling at the note's half-period for the note's
// duration (in ticks of TICK_CYCLES clocks).
//
// Optional build macro: NOTE_GAP_EN -- when defined, a silent GAP state of
// GAP_TICKS ticks is inserted after every note; when undefined, notes play
// back-to-back.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   note_in      [39:20] half-period in clk cycles (0 = rest), [19:0] duration in ticks
//   note_valid   note_in valid this cycle
//   note_ready   FIFO not full (decoded from the registered count)
//   enable       playback enable, low pauses everything
//   tone         registered square-wave output
//   playing      high while a note (or gap) is in progress
//   fifo_count   number of buffered notes
//   underrun     one-cycle pulse when a note ends with the FIFO empty
module note_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TICK_CYCLES = 48000,
    parameter int GAP_TICKS   = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [39:0]                 note_in,
    input  logic                        note_valid,
    output logic                        note_ready,
    input  logic                        enable,
    output logic                        tone,
    output logic                        playing,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        underrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [19:0] TICK_LAST = 20'(TICK_CYCLES - 1);
`ifdef NOTE_GAP_EN
    localparam logic [19:0] GAP_LAST = 20'(GAP_TICKS - 1);
`endif

`ifdef NOTE_GAP_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_GAP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1} state_t;
`endif

    state_t              state_q, state_d;
    logic [39:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [19:0]         period_q, period_d;
    logic [19:0]         dur_q, dur_d;
    logic [19:0]         hp_q, hp_d;
    logic [19:0]         pre_q, pre_d;
    logic                phase_q, phase_d;
    logic                tone_q, tone_d;
    logic                playing_q, playing_d;
    logic                underrun_q, underrun_d;
`ifdef NOTE_GAP_EN
    logic [19:0]         gap_q, gap_d;
`endif

    logic                push_s, pop_s, fifo_empty_s, tick_wrap_s, note_end_s;
    logic [39:0]         head_s;

    assign note_ready   = (count_q != CNT_W'(FIFO_DEPTH));
    assign push_s       = note_valid && note_ready;
    assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
    assign head_s       = mem_q[rd_ptr_q];
    assign tick_wrap_s  = (pre_q == TICK_LAST);

    assign tone       = tone_q;
    assign playing    = playing_q;
    assign fifo_count = count_q;
    assign underrun   = underrun_q;

    // FIFO occupancy: a push and a pop on the same edge leave the count unchanged
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Sequencer next state: note loading, half-period/tick counting, note end
    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        dur_d      = dur_q;
        hp_d       = hp_q;
        pre_d      = pre_q;
        phase_d    = phase_q;
        pop_s      = 1'b0;
        underrun_d = 1'b0;
        note_end_s = 1'b0;
`ifdef NOTE_GAP_EN
        gap_d      = gap_q;
`endif
        case (state_q)
            ST_IDLE: begin
                phase_d = 1'b0;
                if (enable && !fifo_empty_s) begin
                    pop_s    = 1'b1;
                    period_d = head_s[39:20];
                    dur_d    = head_s[19:0];
                    hp_d     = 20'd0;
                    pre_d    = 20'd0;
                    state_d  = ST_PLAY;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_PLAY: begin
                // Everything holds while paused, so the phase resumes intact
                if (enable) begin
                    if (period_q == 20'd0) begin
                        phase_d = 1'b0;
                    end else if (hp_q == period_q - 20'd1) begin
                        hp_d    = 20'd0;
                        phase_d = ~phase_q;
                    end else begin
                        hp_d    = hp_q + 20'd1;
                    end
                    if (tick_wrap_s) begin
                        pre_d = 20'd0;
                        if (dur_q != 20'd0) begin
                            dur_d = dur_q - 20'd1;
                        end else begin
                            dur_d = dur_q;
                        end
                    end else begin
                        pre_d = pre_q + 20'd1;
                    end
                    // A zero-duration note ends after its first PLAY cycle
                    note_end_s = (dur_q == 20'd0) || (tick_wrap_s && (dur_q == 20'd1));
                    if (note_end_s) begin
                        phase_d = 1'b0;
                        hp_d    = 20'd0;
                        pre_d   = 20'd0;
`ifdef NOTE_GAP_EN
                        gap_d      = 20'd0;
                        state_d    = ST_GAP;
                        underrun_d = fifo_empty_s;
`else
                        if (!fifo_empty_s) begin
                            pop_s    = 1'b1;
                            period_d = head_s[39:20];
                            dur_d    = head_s[19:0];
                        end else begin
                            state_d    = ST_IDLE;
                            underrun_d = 1'b1;
                        end
`endif
                    end else begin
                        state_d = ST_PLAY;
                    end
                end else begin
                    state_d = ST_PLAY;
                end
            end
`ifdef NOTE_GAP_EN
            ST_GAP: begin
                if (enable) begin
                    if (tick_wrap_s) begin
                        pre_d = 20'd0;
                        if (gap_q == GAP_LAST) begin
                            if (!fifo_empty_s) begin
                                pop_s    = 1'b1;
                                period_d = head_s[39:20];
                                dur_d    = head_s[19:0];
                                hp_d     = 20'd0;
                                state_d  = ST_PLAY;
                            end else begin
                                state_d  = ST_IDLE;
                            end
                        end else begin
                            gap_d = gap_q + 20'd1;
                        end
                    end else begin
                        pre_d = pre_q + 20'd1;
                    end
                end else begin
                    state_d = ST_GAP;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Output decode from next state; tone is silenced while paused
        tone_d    = (state_d == ST_PLAY) && enable && phase_d;
        playing_d = (state_d != ST_IDLE);
    end

    // FIFO storage (data needs no reset: only slots covered by count are read)
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            mem_q[wr_ptr_q] <= note_in;
        end
    end

    // FIFO pointers/count and sequencer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            state_q    <= ST_IDLE;
            period_q   <= 20'd0;
            dur_q      <= 20'd0;
            hp_q       <= 20'd0;
            pre_q      <= 20'd0;
            phase_q    <= 1'b0;
            tone_q     <= 1'b0;
            playing_q  <= 1'b0;
            underrun_q <= 1'b0;
`ifdef NOTE_GAP_EN
            gap_q      <= 20'd0;
`endif
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q    <= count_d;
            state_q    <= state_d;
            period_q   <= period_d;
            dur_q      <= dur_d;
            hp_q       <= hp_d;
            pre_q      <= pre_d;
            phase_q    <= phase_d;
            tone_q     <= tone_d;
            playing_q  <= playing_d;
            underrun_q <= underrun_d;
`ifdef NOTE_GAP_EN
            gap_q      <= gap_d;
`endif
        end
    end

endmodule
